// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine controller.
// The optional buzzer is enabled by defining SLOT_FSM_BUZZER_EN.
package slot_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int DIGIT_W    = 4;
  localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'd10;
  localparam int SLOW_DIV   = 4;
  localparam int SLOW_CNT_W = $clog2(SLOW_DIV);

  typedef enum logic [1:0] {
    ST_SET  = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_WIN  = 2'd3
  } state_t;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  // Raw 4-bit compare: codes 11-15 are matched like any other value.
  function automatic logic all_equal(input digits_t d);
    logic eq;
    eq = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (d[i] != d[0]) eq = 1'b0;
    end
    return eq;
  endfunction

endpackage

// File: rtl/slot_fsm_blink.sv
// Blink phase generator: synchronizes blinkClk, detects its rising edges and
// derives a fast phase (every edge) and a slow phase (every SLOW_DIV edges).
module blink_gen
  import slot_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_blink,
  input  logic i_clear,
  output logic o_fast,
  output logic o_slow
);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_sync_prev;
  logic                  r_fast;
  logic                  r_slow;
  logic [SLOW_CNT_W-1:0] r_cnt;
  logic                  w_rise;

  assign w_rise = r_sync2 & ~r_sync_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync1     <= i_blink;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  // Clear has priority so a restart always begins in the "shown" phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fast <= 1'b0;
      r_slow <= 1'b0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_fast <= 1'b0;
      r_slow <= 1'b0;
      r_cnt  <= '0;
    end else if (w_rise) begin
      r_fast <= ~r_fast;
      if (r_cnt == SLOW_CNT_W'(SLOW_DIV - 1)) begin
        r_slow <= ~r_slow;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_fast = r_fast;
  assign o_slow = r_slow;

endmodule

// File: rtl/slot_fsm.sv
// Slot machine controller: SET -> RUN -> STOP -> (WIN) with blinking display.
// Define SLOT_FSM_BUZZER_EN to drive the buzzer while in WIN.
module slot_fsm
  import slot_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 button,
  input  logic                                 blinkClk,
  input  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   slotNums,
  output logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   displayNums,
  output logic                                 slotRunning,
  output logic                                 buzzer
);

  state_t  r_state;
  state_t  w_state_next;
  logic    r_btn_prev;
  logic    w_press;
  logic    w_equal;
  logic    w_fast;
  logic    w_slow;
  logic    w_clear;
  digits_t r_disp;
  digits_t w_disp_next;
  digits_t w_blank;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      assign w_blank[gi] = BLANK_DIGIT;
    end
  endgenerate

  assign w_press = button & ~r_btn_prev;
  assign w_equal = all_equal(slotNums);

  blink_gen u_blink (
    .clk     (clk),
    .rst     (rst),
    .i_blink (blinkClk),
    .i_clear (w_clear),
    .o_fast  (w_fast),
    .o_slow  (w_slow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_SET;
      r_btn_prev <= 1'b0;
      r_disp     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_btn_prev <= button;
      r_disp     <= w_disp_next;
    end
  end

  // A press always wins over an equality seen in the same STOP cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SET:  if (w_press) w_state_next = ST_RUN;
      ST_RUN:  if (w_press) w_state_next = ST_STOP;
      ST_STOP: begin
        if (w_press)      w_state_next = ST_RUN;
        else if (w_equal) w_state_next = ST_WIN;
      end
      ST_WIN:  if (w_press) w_state_next = ST_RUN;
      default: w_state_next = ST_SET;
    endcase
    w_clear = (w_state_next == ST_RUN);
  end

  always_comb begin
    w_disp_next = '0;
    slotRunning = 1'b0;
    case (r_state)
      ST_SET:  w_disp_next = '0;
      ST_RUN: begin
        w_disp_next = slotNums;
        slotRunning = 1'b1;
      end
      ST_STOP: w_disp_next = w_fast ? w_blank : slotNums;
      ST_WIN:  w_disp_next = w_slow ? w_blank : slotNums;
      default: w_disp_next = '0;
    endcase
  end

  assign displayNums = r_disp;

`ifdef SLOT_FSM_BUZZER_EN
  assign buzzer = (r_state == ST_WIN);
`else
  assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_slot_fsm.sv
// Directed, table-driven bench for slot_fsm plus hand-written reset and
// held-button sequences.
module tb_slot_fsm;

`ifdef SLOT_FSM_BUZZER_EN
  localparam logic BZ = 1'b1;
`else
  localparam logic BZ = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             button;
  logic             blinkClk;
  logic [2:0][3:0]  slot_nums;
  logic [2:0][3:0]  display_nums;
  logic             slot_running;
  logic             buzzer;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        btn;
    logic        blk;
    logic [11:0] slot;
    int          n;
    logic [11:0] disp;
    logic        run;
    logic        bz;
    string       name;
  } vec_t;

  vec_t vt[$];

  slot_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .button      (button),
    .blinkClk    (blinkClk),
    .slotNums    (slot_nums),
    .displayNums (display_nums),
    .slotRunning (slot_running),
    .buzzer      (buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [11:0] d, input logic r, input logic b);
    chk({name, ".disp"}, display_nums, d);
    chk({name, ".run"}, {11'd0, slot_running}, {11'd0, r});
    chk({name, ".buzz"}, {11'd0, buzzer}, {11'd0, b});
  endtask

  task automatic add(input logic btn, input logic blk, input logic [11:0] slot, input int n,
                     input logic [11:0] disp, input logic run, input logic bz, input string name);
    vec_t v;
    v.btn = btn; v.blk = blk; v.slot = slot; v.n = n;
    v.disp = disp; v.run = run; v.bz = bz; v.name = name;
    vt.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //   btn  blk  slot     n  disp     run   bz   name
    add(1'b0, 1'b0, 12'h303, 2, 12'h000, 1'b0, 1'b0, "set_idle");
    add(1'b1, 1'b0, 12'h303, 1, 12'h000, 1'b1, 1'b0, "set_press");
    add(1'b1, 1'b0, 12'h303, 1, 12'h303, 1'b1, 1'b0, "run_latency_held");
    add(1'b0, 1'b0, 12'h123, 1, 12'h123, 1'b1, 1'b0, "run_follow");
    add(1'b0, 1'b0, 12'h303, 1, 12'h303, 1'b1, 1'b0, "run_follow2");
    add(1'b1, 1'b0, 12'h303, 1, 12'h303, 1'b0, 1'b0, "run_press_stop");
    add(1'b0, 1'b0, 12'h303, 2, 12'h303, 1'b0, 1'b0, "stop_shown");
    add(1'b0, 1'b1, 12'h303, 5, 12'hAAA, 1'b0, 1'b0, "stop_blank_e1");
    add(1'b0, 1'b0, 12'h303, 5, 12'hAAA, 1'b0, 1'b0, "stop_fall");
    add(1'b0, 1'b1, 12'h303, 5, 12'h303, 1'b0, 1'b0, "stop_shown_e2");
    add(1'b0, 1'b1, 12'h333, 1, 12'h333, 1'b0, BZ,   "stop_eq_win");
    add(1'b0, 1'b0, 12'h333, 5, 12'h333, 1'b0, BZ,   "win_fall");
    add(1'b0, 1'b1, 12'h333, 5, 12'h333, 1'b0, BZ,   "win_e3");
    add(1'b0, 1'b0, 12'h333, 5, 12'h333, 1'b0, BZ,   "win_fall2");
    add(1'b0, 1'b1, 12'h333, 5, 12'hAAA, 1'b0, BZ,   "win_e4_slow");
    add(1'b0, 1'b0, 12'h333, 5, 12'hAAA, 1'b0, BZ,   "win_fall3");
    add(1'b0, 1'b1, 12'h333, 5, 12'hAAA, 1'b0, BZ,   "win_e5");
    add(1'b1, 1'b1, 12'h333, 1, 12'hAAA, 1'b1, 1'b0, "win_press");
    add(1'b0, 1'b1, 12'h121, 1, 12'h121, 1'b1, 1'b0, "run_after_win");
    add(1'b1, 1'b1, 12'h121, 1, 12'h121, 1'b0, 1'b0, "run_press_stop2");
    add(1'b0, 1'b1, 12'h121, 2, 12'h121, 1'b0, 1'b0, "stop_fast_cleared");
    add(1'b0, 1'b1, 12'h777, 1, 12'h777, 1'b0, BZ,   "stop_eq_win2");
    add(1'b0, 1'b1, 12'h777, 3, 12'h777, 1'b0, BZ,   "win_slow_cleared");
    add(1'b1, 1'b1, 12'h777, 1, 12'h777, 1'b1, 1'b0, "win_press2");
    add(1'b0, 1'b1, 12'h121, 1, 12'h121, 1'b1, 1'b0, "run_121");
    add(1'b1, 1'b1, 12'h121, 1, 12'h121, 1'b0, 1'b0, "run_press_stop3");
    add(1'b0, 1'b1, 12'h121, 1, 12'h121, 1'b0, 1'b0, "stop_wait");
    add(1'b1, 1'b1, 12'h555, 1, 12'h555, 1'b1, 1'b0, "press_beats_eq");
    add(1'b0, 1'b1, 12'h555, 1, 12'h555, 1'b1, 1'b0, "run_555");
    add(1'b0, 1'b1, 12'hFBE, 1, 12'hFBE, 1'b1, 1'b0, "run_raw_codes");
    add(1'b1, 1'b1, 12'hCCC, 1, 12'hCCC, 1'b0, 1'b0, "run_press_ccc");
    add(1'b0, 1'b1, 12'hCCC, 1, 12'hCCC, 1'b0, BZ,   "raw_eq_win");
    add(1'b1, 1'b1, 12'hCCC, 1, 12'hCCC, 1'b1, 1'b0, "win_press3");

    rst = 1'b1; button = 1'b0; blinkClk = 1'b0; slot_nums = 12'h000;
    #2 rst = 1'b0;
    #2 chk_all("reset", 12'h000, 1'b0, 1'b0);
    $display("reset: disp=%h run=%b buzz=%b", display_nums, slot_running, buzzer);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      button    = vt[i].btn;
      blinkClk  = vt[i].blk;
      slot_nums = vt[i].slot;
      step(vt[i].n);
      chk_all(vt[i].name, vt[i].disp, vt[i].run, vt[i].bz);
      $display("%s: disp=%h run=%b buzz=%b", vt[i].name, display_nums, slot_running, buzzer);
    end

    // Asynchronous reset in the middle of RUN, checked before any clock edge.
    button = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all("async_reset_run", 12'h000, 1'b0, 1'b0);
    $display("async_reset_run: disp=%h run=%b buzz=%b", display_nums, slot_running, buzzer);

    // Button held high for 10 clocks from SET: a single transition to RUN.
    @(negedge clk);
    rst = 1'b1;
    button = 1'b1;
    step(1);
    chk_all("hold_first", 12'h000, 1'b1, 1'b0);
    $display("hold_first: disp=%h run=%b", display_nums, slot_running);
    step(9);
    chk_all("hold_tenth", 12'hCCC, 1'b1, 1'b0);
    $display("hold_tenth: disp=%h run=%b", display_nums, slot_running);
    button = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
